// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Six-digit dynamic-scan driver for a common-anode seven-segment display.
// A 24-bit packed BCD word and six decimal-point bits are captured into a
// shadow register on bcd_valid. A free-running slot counter steps the digit
// index 0..5, and one digit is driven per scan slot.
//
// Optional feature: define SEG_LZB_EN to enable leading-zero blanking.
// Digits above the highest nonzero digit or the highest lit decimal point are
// blanked. Their select line keeps scanning. Digit 0 is never blanked.
//
// Parameters
//   CNT_MAX   scan slot length minus one, in clocks (1 .. 2^20-1)
// Ports
//   sys_clk   system clock, rising edge
//   sys_rst   synchronous active-high reset
//   bcd_in    packed BCD, [3:0] = ones ... [23:20] = hundred-thousands
//   bcd_valid single-cycle load strobe for bcd_in / dot_in
//   dot_in    decimal point per digit (bit k = digit k)
//   disp_en   level-sensitive display enable
//   sel       digit select, active-low, bit 0 = ones digit (registered)
//   seg       segments {dp,g,f,e,d,c,b,a}, active-low (registered)
//
// Handshake: bcd_valid is a pure strobe with no ready. Every edge with
// bcd_valid=1 overwrites the shadow register, so the last strobe wins. Reset
// has priority over a coincident strobe.
module seg_scan_driver #(
  parameter int unsigned CNT_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [23:0] bcd_in,
  input  logic        bcd_valid,
  input  logic [5:0]  dot_in,
  input  logic        disp_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam logic [19:0] CNT_LAST = 20'(CNT_MAX);

  logic [19:0] cnt_q;
  logic [2:0]  idx_q;
  logic [23:0] bcd_q;
  logic [5:0]  dot_q;
  logic [5:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;

  logic [3:0]  nib;
  logic        dot_bit;
  logic [6:0]  glyph;
  logic        blank;

  // Current digit and its decimal point, selected from the shadow register.
  always_comb begin
    nib     = bcd_q[3:0];
    dot_bit = dot_q[0];
    case (idx_q)
      3'd1:    begin nib = bcd_q[7:4];   dot_bit = dot_q[1]; end
      3'd2:    begin nib = bcd_q[11:8];  dot_bit = dot_q[2]; end
      3'd3:    begin nib = bcd_q[15:12]; dot_bit = dot_q[3]; end
      3'd4:    begin nib = bcd_q[19:16]; dot_bit = dot_q[4]; end
      3'd5:    begin nib = bcd_q[23:20]; dot_bit = dot_q[5]; end
      default: begin nib = bcd_q[3:0];   dot_bit = dot_q[0]; end
    endcase
  end

  // Active-low {g..a}. Non-decimal codes show a dash.
  always_comb begin
    glyph = 7'h3F;
    case (nib)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase
  end

`ifdef SEG_LZB_EN
  // hi_pos is the highest digit that carries a nonzero value or a lit dot.
  // It is never below 0, so digit 0 always shows.
  logic [2:0] hi_pos;
  always_comb begin
    hi_pos = 3'd0;
    for (int k = 1; k < 6; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0 || dot_q[k]) hi_pos = 3'(k);
    end
    blank = (idx_q > hi_pos);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    sel_d = 6'h3F;
    seg_d = 8'hFF;
    if (disp_en) begin
      sel_d = ~(6'b000001 << idx_q);
      if (!blank) seg_d = {~dot_bit, glyph};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      bcd_q <= '0;
      dot_q <= '0;
      sel_q <= 6'h3F;
      seg_q <= 8'hFF;
    end else begin
      if (bcd_valid) begin
        bcd_q <= bcd_in;
        dot_q <= dot_in;
      end
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= (idx_q == 3'd5) ? 3'd0 : 3'(idx_q + 3'd1);
      end else begin
        cnt_q <= 20'(cnt_q + 20'd1);
      end
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int CNT_MAX = 3;
  localparam int SLOT    = CNT_MAX + 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [23:0] bcd_in;
  logic        bcd_valid;
  logic [5:0]  dot_in;
  logic        disp_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  initial forever #5 sys_clk = ~sys_clk;

  seg_scan_driver #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .dot_in    (dot_in),
    .disp_en   (disp_en),
    .sel       (sel),
    .seg       (seg)
  );

  // ---------------- reference model ----------------
  // Scan position is derived purely from the number of clocks since reset:
  // digit = floor(clocks / slot_len) mod 6.
  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    logic [6:0] tab [10];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (v > 4'd9) return 7'h3F;
    return tab[v];
  endfunction

  function automatic logic is_blank(input logic [23:0] b, input logic [5:0] d, input int digit);
`ifdef SEG_LZB_EN
    int h = 0;
    for (int k = 0; k < 6; k++)
      if (((b >> (4*k)) & 24'hF) != 24'h0 || d[k]) h = k;
    return digit > h;
`else
    return 1'b0;
`endif
  endfunction

  int          clk_since_rst = 0;
  logic [23:0] m_bcd = '0;
  logic [5:0]  m_dot = '0;
  logic [5:0]  exp_sel;
  logic [7:0]  exp_seg;
  bit          model_live = 0;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      exp_sel = 6'h3F;
      exp_seg = 8'hFF;
      clk_since_rst = 0;
      m_bcd = '0;
      m_dot = '0;
      model_live = 1;
    end else begin
      int d;
      d = (clk_since_rst / SLOT) % 6;
      if (disp_en) begin
        exp_sel = 6'h3F & ~(6'(1) << d);
        if (is_blank(m_bcd, m_dot, d)) exp_seg = 8'hFF;
        else exp_seg = {~m_dot[d], glyph_of(4'((m_bcd >> (4*d)) & 24'hF))};
      end else begin
        exp_sel = 6'h3F;
        exp_seg = 8'hFF;
      end
      if (bcd_valid) begin
        m_bcd = bcd_in;
        m_dot = dot_in;
      end
      clk_since_rst++;
    end
    #1;
    if (model_live) begin
      checks++;
      if (sel !== exp_sel || seg !== exp_seg) begin
        errors++;
        $display("FAIL model t=%0t sel=%h seg=%h want sel=%h seg=%h", $time, sel, seg, exp_sel, exp_seg);
      end
    end
  end

  // ---------------- driver / literal-check tasks ----------------
  task automatic check_lit(input string nm, input logic [5:0] es, input logic [7:0] eg);
    checks++;
    if (sel !== es || seg !== eg) begin
      errors++;
      $display("FAIL %s sel=%h seg=%h want sel=%h seg=%h", nm, sel, seg, es, eg);
    end
  endtask

  task automatic wait_sel(input logic [5:0] t, input string nm);
    int n = 0;
    while (sel !== t && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (sel !== t) begin
      checks++;
      errors++;
      $display("FAIL %s timeout sel=%h want %h", nm, sel, t);
    end
  endtask

  task automatic load(input logic [23:0] b, input logic [5:0] d);
    bcd_in    = b;
    dot_in    = d;
    bcd_valid = 1'b1;
    @(negedge sys_clk);
    bcd_valid = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic check_frame(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input logic [7:0] e4, input logic [7:0] e5);
    logic [7:0] ex [6];
    logic [5:0] st [6];
    ex = '{e0, e1, e2, e3, e4, e5};
    st = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    for (int i = 0; i < 6; i++) begin
      wait_sel(st[i], nm);
      check_lit($sformatf("%s_d%0d", nm, i), st[i], ex[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0]  walk_sel [6];
    logic [7:0]  w_seg;
    logic [23:0] rb;
    walk_sel = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    sys_rst = 1'b1; bcd_in = '0; bcd_valid = 1'b0; dot_in = '0; disp_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_lit("reset", 6'h3F, 8'hFF);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Reset walk: each digit held for SLOT clocks, all showing "0".
    for (int j = 0; j < 6*SLOT; j++) begin
`ifdef SEG_LZB_EN
      w_seg = (j / SLOT == 0) ? 8'hC0 : 8'hFF;
`else
      w_seg = 8'hC0;
`endif
      check_lit($sformatf("walk%0d", j), walk_sel[j / SLOT], w_seg);
      @(negedge sys_clk);
    end

    load(24'h123456, 6'b000100);
    check_frame("ld123456", 8'h82, 8'h92, 8'h19, 8'hB0, 8'hA4, 8'hF9);

    load(24'h00000A, 6'b000000);
    wait_sel(6'h3E, "dash");
    check_lit("dash", 6'h3E, 8'hBF);

`ifdef SEG_LZB_EN
    load(24'h000042, 6'b000000);
    check_frame("lzb42", 8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    load(24'h000005, 6'b000100);
    check_frame("lzb005", 8'h92, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF);
`endif

    // Back-to-back strobes: last one wins.
    bcd_in = 24'h999999; dot_in = 6'h3F; bcd_valid = 1'b1;
    @(negedge sys_clk);
    bcd_in = 24'h000777; dot_in = 6'h00;
    @(negedge sys_clk);
    bcd_valid = 1'b0;
    @(negedge sys_clk);
    wait_sel(6'h3E, "b2b");
    check_lit("b2b", 6'h3E, 8'hF8);

    // Mid-frame reset at digit 3, with a coincident strobe.
    load(24'h888888, 6'h00);
    wait_sel(6'h37, "rst_mid");
    sys_rst = 1'b1; bcd_valid = 1'b1; bcd_in = 24'h555555;
    @(negedge sys_clk);
    check_lit("rst_mid", 6'h3F, 8'hFF);
    sys_rst = 1'b0; bcd_valid = 1'b0;
    @(negedge sys_clk);
    check_lit("rst_resume", 6'h3E, 8'hC0);

    // Display gap of 10 clocks; scanning continues underneath.
    repeat (5) @(negedge sys_clk);
    disp_en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge sys_clk);
      check_lit($sformatf("gap%0d", j), 6'h3F, 8'hFF);
    end
    disp_en = 1'b1;
    @(negedge sys_clk);
    // 5 + 10 + 1 = 16 clocks after resume edge -> idx 16/4 = 4.
    check_lit("reenable", 6'h2F, 8'hC0);

    // Randomized phase, checked cycle-by-cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      bcd_valid = ($urandom_range(0, 15) == 0);
      rb = '0;
      for (int k = 0; k < 6; k++) begin
        case ($urandom_range(0, 3))
          0:       rb[4*k +: 4] = 4'd0;
          1:       rb[4*k +: 4] = 4'($urandom_range(0, 15));
          default: rb[4*k +: 4] = 4'($urandom_range(0, 9));
        endcase
      end
      bcd_in = rb;
      dot_in = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'h00;
      if ($urandom_range(0, 29) == 0) disp_en = ~disp_en;
      sys_rst = ($urandom_range(0, 399) == 0);
      @(negedge sys_clk);
    end
    sys_rst = 1'b0;
    bcd_valid = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
